// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path.
//   rx_state_e  : deframer FSM states
//   ERR_*       : bit positions inside the 3-bit Rx_Error vector
//   frame_len() : total bit times in one frame, start bit included
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DATA,
      PARITY,
      STOP,
      BREAK_WAIT
   } rx_state_e;

   localparam int ERR_BREAK  = 0;
   localparam int ERR_PARITY = 1;
   localparam int ERR_FRAME  = 2;

   function automatic int frame_len(input int data_bits,
                                    input int parity_bit,
                                    input int stop_bits);
      return 1 + data_bits + parity_bit + stop_bits;
   endfunction

endpackage

// File: rtl/uart_rx_deframer.sv
// -----------------------------------------------------------------------------
// uart_rx_deframer
// Serial receive front end: samples the line once per baud clock, deframes
// start / data (MSB first) / even parity / stop bits, flags break, parity and
// framing errors, and hands error-free bytes to the receive FIFO.
//
// Parameters
//   DATA_BITS  : data bits per frame (>= 2)
//   PARITY_BIT : 1 = one even-parity bit follows the data, 0 = none
//   STOP_BITS  : number of stop bits, each must be 1
//
// Ports
//   Clk        in   baud clock, one bit time per cycle
//   Rst        in   synchronous active-high reset
//   Rx         in   serial input, idle high
//   FIFO_Full  in   downstream FIFO full flag
//   Data_Out   out  last error-free byte
//   Data_Rdy   out  one-cycle strobe, Data_Out is new
//   Rx_Error   out  [0] break, [1] parity, [2] frame; held until next start bit
//   RTS        out  ready to receive (idle next cycle and FIFO not full)
//
// Optional build macro UART_RX_BIST_LOOPBACK_EN adds:
//   BIST_Mode  in   select loopback source (sampled only in IDLE)
//   Tx_Loop    in   loopback serial source
//   Bist_Rdy   out  replaces Data_Rdy while in loopback mode
// -----------------------------------------------------------------------------
module uart_rx_deframer
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int PARITY_BIT = 1,
   parameter int STOP_BITS  = 2
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 Rx,
   input  logic                 FIFO_Full,
`ifdef UART_RX_BIST_LOOPBACK_EN
   input  logic                 BIST_Mode,
   input  logic                 Tx_Loop,
   output logic                 Bist_Rdy,
`endif
   output logic [DATA_BITS-1:0] Data_Out,
   output logic                 Data_Rdy,
   output logic [2:0]           Rx_Error,
   output logic                 RTS
);

   localparam int CNT_MAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   rx_state_e            state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [DATA_BITS-1:0] sh_q;
   logic [DATA_BITS-1:0] data_out_q;
   logic                 par_q;
   logic                 all_zero_q;   // every sample of this frame so far was 0
   logic                 stop_zero_q;  // an earlier stop sample was 0
   logic                 data_rdy_q;
   logic                 rts_q;
   logic [2:0]           rx_error_q;

   logic                 src;
   logic                 par_err;
   logic                 brk_d;
   logic                 idle_nxt_d;
   logic [2:0]           err_d;

`ifdef UART_RX_BIST_LOOPBACK_EN
   logic bist_q;
   logic bist_rdy_q;
   logic bist_sel;

   // Mode is live while idle so the start bit is taken from the right source,
   // then frozen for the rest of the frame.
   assign bist_sel = (state_q == IDLE) ? BIST_Mode : bist_q;
   assign src      = bist_sel ? Tx_Loop : Rx;
   assign Bist_Rdy = bist_rdy_q;
`else
   assign src = Rx;
`endif

   // Evaluation terms for the last stop sample, which is the live src bit.
   assign par_err = (PARITY_BIT != 0) && ((^sh_q) != par_q);
   assign brk_d   = all_zero_q & ~src;

   always_comb begin
      err_d             = '0;
      err_d[ERR_PARITY] = par_err;
      err_d[ERR_FRAME]  = stop_zero_q | ~src;
   end

   // RTS is registered from the next state, so it needs to know now whether
   // the FSM will sit in IDLE after this edge.
   always_comb begin
      idle_nxt_d = 1'b0;
      case (state_q)
         IDLE:       idle_nxt_d = src;
         STOP:       idle_nxt_d = (cnt_q == '0) && !brk_d;
         BREAK_WAIT: idle_nxt_d = src;
         default:    idle_nxt_d = 1'b0;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         par_q       <= 1'b0;
         all_zero_q  <= 1'b0;
         stop_zero_q <= 1'b0;
         data_out_q  <= '0;
         data_rdy_q  <= 1'b0;
         rx_error_q  <= '0;
         rts_q       <= 1'b0;
`ifdef UART_RX_BIST_LOOPBACK_EN
         bist_q      <= 1'b0;
         bist_rdy_q  <= 1'b0;
`endif
      end else begin
         data_rdy_q <= 1'b0;
`ifdef UART_RX_BIST_LOOPBACK_EN
         bist_rdy_q <= 1'b0;
`endif
         rts_q      <= idle_nxt_d & ~FIFO_Full;

         case (state_q)
            IDLE: begin
               if (!src) begin
                  cnt_q       <= CNT_W'(DATA_BITS - 1);
                  rx_error_q  <= '0;
                  all_zero_q  <= 1'b1;
                  stop_zero_q <= 1'b0;
                  state_q     <= DATA;
`ifdef UART_RX_BIST_LOOPBACK_EN
                  bist_q      <= BIST_Mode;
`endif
               end
            end

            DATA: begin
               sh_q <= {sh_q[DATA_BITS-2:0], src};
               if (src) all_zero_q <= 1'b0;
               if (cnt_q == '0) begin
                  cnt_q   <= CNT_W'(STOP_BITS - 1);
                  state_q <= (PARITY_BIT != 0) ? PARITY : STOP;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end

            PARITY: begin
               par_q   <= src;
               if (src) all_zero_q <= 1'b0;
               state_q <= STOP;
            end

            STOP: begin
               if (src) all_zero_q  <= 1'b0;
               else     stop_zero_q <= 1'b1;
               if (cnt_q == '0) begin
                  if (brk_d) begin
                     // Break reports alone; parity/frame flags are meaningless.
                     rx_error_q            <= '0;
                     rx_error_q[ERR_BREAK] <= 1'b1;
                     state_q               <= BREAK_WAIT;
                  end else begin
                     rx_error_q <= err_d;
                     state_q    <= IDLE;
                     if (err_d == '0) begin
                        data_out_q <= sh_q;
`ifdef UART_RX_BIST_LOOPBACK_EN
                        if (bist_q) bist_rdy_q <= 1'b1;
                        else        data_rdy_q <= 1'b1;
`else
                        data_rdy_q <= 1'b1;
`endif
                     end
                  end
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end

            BREAK_WAIT: begin
               if (src) state_q <= IDLE;
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign Data_Out = data_out_q;
   assign Data_Rdy = data_rdy_q;
   assign Rx_Error = rx_error_q;
   assign RTS      = rts_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_deframer
// Randomised frames with a frame-level reference model; expected bytes go to a
// scoreboard queue that a monitor drains on every Data_Rdy strobe.
// -----------------------------------------------------------------------------
module tb_uart_rx_deframer;

   logic       Clk = 1'b0;
   logic       Rst = 1'b1;
   logic       Rx = 1'b1;
   logic       FIFO_Full = 1'b0;
   logic [7:0] Data_Out;
   logic       Data_Rdy;
   logic [2:0] Rx_Error;
   logic       RTS;
`ifdef UART_RX_BIST_LOOPBACK_EN
   logic       BIST_Mode = 1'b0;
   logic       Tx_Loop = 1'b1;
   logic       Bist_Rdy;
`endif

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   logic [7:0] sb[$];
   int         rdy_times[$];
   logic [7:0] last_good = 8'h00;

   uart_rx_deframer #(.DATA_BITS(8), .PARITY_BIT(1), .STOP_BITS(2)) dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .Rx        (Rx),
      .FIFO_Full (FIFO_Full),
`ifdef UART_RX_BIST_LOOPBACK_EN
      .BIST_Mode (BIST_Mode),
      .Tx_Loop   (Tx_Loop),
      .Bist_Rdy  (Bist_Rdy),
`endif
      .Data_Out  (Data_Out),
      .Data_Rdy  (Data_Rdy),
      .Rx_Error  (Rx_Error),
      .RTS       (RTS)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) cycle <= cycle + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // Monitor: every strobe must match the oldest outstanding expected byte.
   always @(negedge Clk) begin
      if (!Rst && Data_Rdy === 1'b1) begin
         rdy_times.push_back(cycle);
         if (sb.size() == 0) begin
            chk("unexpected_data_rdy", {24'h0, Data_Out}, 32'hFFFF_FFFF);
         end else begin
            chk("data_rdy_byte", {24'h0, Data_Out}, {24'h0, sb.pop_front()});
         end
      end
   end

   // Drive one bit; returns 1 time unit after the edge that sampled it.
   task automatic send_bit(input logic b);
      Rx = b;
      @(posedge Clk);
      #1;
   endtask

   // Reference model: outcome of a whole frame from its fields.
   function automatic logic [2:0] model_err(input logic [7:0] d, input logic p,
                                            input logic [1:0] st);
      logic [2:0] e;
      if (d == 8'h00 && p == 1'b0 && st == 2'b00) e = 3'b001;
      else begin
         e    = 3'b000;
         e[1] = ((^d) != p);
         e[2] = (st != 2'b11);
      end
      return e;
   endfunction

   task automatic send_frame(input logic [7:0] d, input logic p, input logic [1:0] st,
                             input bit ff_mid);
      logic [11:0] bits;
      logic [2:0]  e;
      bits = {1'b0, d, p, st};
      e    = model_err(d, p, st);
      for (int i = 11; i >= 0; i--) begin
         if (i == 0 && e == 3'b000) sb.push_back(d);
         send_bit(bits[i]);
         if (i == 11) begin
            chk("rts_after_start", {31'h0, RTS}, 32'h0);
            chk("err_clear_on_start", {29'h0, Rx_Error}, 32'h0);
            if (ff_mid) FIFO_Full = 1'b1;
         end
      end
      if (e == 3'b000) last_good = d;
      chk("rx_error", {29'h0, Rx_Error}, {29'h0, e});
      chk("data_out_hold", {24'h0, Data_Out}, {24'h0, last_good});
      chk("rts_end", {31'h0, RTS}, {31'h0, (e != 3'b001) && !FIFO_Full});
      if (e == 3'b001) begin
         send_bit(1'b0);
         send_bit(1'b0);
         chk("break_rts_low", {31'h0, RTS}, 32'h0);
         chk("break_err_held", {29'h0, Rx_Error}, 32'h1);
         send_bit(1'b1);
         chk("break_exit_rts", {31'h0, RTS}, {31'h0, !FIFO_Full});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [7:0] d;
      logic       p;
      logic [1:0] st;

      // Reset
      Rst = 1'b1;
      repeat (3) @(posedge Clk);
      #1;
      chk("rst_data_out", {24'h0, Data_Out}, 32'h0);
      chk("rst_data_rdy", {31'h0, Data_Rdy}, 32'h0);
      chk("rst_rx_error", {29'h0, Rx_Error}, 32'h0);
      chk("rst_rts", {31'h0, RTS}, 32'h0);
      Rst = 1'b0;
      send_bit(1'b1);
      chk("rts_after_rst", {31'h0, RTS}, 32'h1);

      // Directed frames
      send_frame(8'hA5, 1'b0, 2'b11, 0);
      send_bit(1'b1);
      send_frame(8'hAA, 1'b1, 2'b11, 0);
      send_bit(1'b1);
      chk("parity_err_held", {29'h0, Rx_Error}, 32'h2);
      send_frame(8'hAA, 1'b0, 2'b00, 0);
      send_bit(1'b1);
      send_frame(8'h00, 1'b0, 2'b00, 0);
      send_frame(8'h3C, 1'b0, 2'b11, 0);
      send_bit(1'b1);

      // FIFO_Full in IDLE, then release and burst eight frames back-to-back
      FIFO_Full = 1'b1;
      send_bit(1'b1);
      chk("rts_fifo_full", {31'h0, RTS}, 32'h0);
      FIFO_Full = 1'b0;
      send_bit(1'b1);
      chk("rts_fifo_release", {31'h0, RTS}, 32'h1);
      rdy_times.delete();
      for (int i = 0; i < 8; i++) send_frame(8'(i), ^8'(i), 2'b11, 0);
      send_bit(1'b1);
      chk("burst_pulses", rdy_times.size(), 8);
      for (int i = 1; i < rdy_times.size(); i++)
         chk("burst_spacing", rdy_times[i] - rdy_times[i-1], 12);

      // FIFO_Full rising mid-frame must not suppress the strobe
      send_frame(8'h81, 1'b0, 2'b11, 1);
      FIFO_Full = 1'b0;
      send_bit(1'b1);

      // Reset during data bit 4 of 0xFF
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      Rst = 1'b1;
      send_bit(1'b1);
      chk("midrst_data_out", {24'h0, Data_Out}, 32'h0);
      chk("midrst_data_rdy", {31'h0, Data_Rdy}, 32'h0);
      chk("midrst_rx_error", {29'h0, Rx_Error}, 32'h0);
      chk("midrst_rts", {31'h0, RTS}, 32'h0);
      Rst = 1'b0;
      last_good = 8'h00;
      send_bit(1'b1);
      chk("midrst_rts_back", {31'h0, RTS}, 32'h1);
      send_frame(8'h55, 1'b0, 2'b11, 0);
      chk("after_rst_byte", {24'h0, Data_Out}, 32'h55);

      // Randomised frames with occasional parity/stop corruption and gaps
      for (int n = 0; n < 40; n++) begin
         d  = 8'($urandom);
         p  = (^d) ^ ($urandom_range(0, 4) == 0);
         st = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b11;
         if ($urandom_range(0, 9) == 0) begin
            d = 8'h00; p = 1'b0; st = 2'b00;
         end
         send_frame(d, p, st, 0);
         for (int g = $urandom_range(0, 2); g > 0; g--) send_bit(1'b1);
      end
      send_bit(1'b1);
      send_bit(1'b1);

      chk("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
